// File: rtl/graph_lut_pkg.sv
// graph_lut_pkg: shared types and constants for the graph LUT stream engine.
//   state_t     - job sequencer states
//   SQRT_SCALE  - fixed-point scale of the power-up SQRT table
//   sqrt_init() - power-up value of one table entry
package graph_lut_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam int SQRT_SCALE = 32;

  // Entry for index idx: the index is a signed idx_w value s.
  // sqrt(s/k)*k == sqrt(s*k), so an integer root of s*k is rounded to nearest.
  // (r+0.5)^2 = r^2+r+0.25, so rounding up is needed exactly when x > r^2+r.
  function automatic int sqrt_init(input int idx, input int idx_w, input int out_w);
    int s;
    int x;
    int r;
    int vmax;
    s = (idx >= (1 << (idx_w - 1))) ? idx - (1 << idx_w) : idx;
    if (s <= 0) return 0;
    x = s * SQRT_SCALE;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    if (x > r * r + r) r++;
    vmax = (1 << (out_w - 1)) - 1;
    if (r > vmax) r = vmax;
    return r;
  endfunction

endpackage

// File: rtl/graph_lut_bank.sv
// graph_lut_bank: table storage shared by all lanes.
// Optional macro: GRAPH_LUT_READBACK_EN adds a registered readback port.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset (read regs only)
//   i_we, i_waddr, i_wdata table write port (caller qualifies i_we)
//   i_re, i_raddr          lane read enable and packed lane indices
//   o_rdata                registered packed lane read data
//   i_cfg_re, o_cfg_rdata  readback (GRAPH_LUT_READBACK_EN only), addressed by i_waddr
module graph_lut_bank
  import graph_lut_pkg::*;
#(
  parameter int LANES = 4,
  parameter int IDX_W = 8,
  parameter int OUT_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_we,
  input  logic [IDX_W-1:0]       i_waddr,
  input  logic [OUT_W-1:0]       i_wdata,
  input  logic                   i_re,
  input  logic [LANES*IDX_W-1:0] i_raddr,
  output logic [LANES*OUT_W-1:0] o_rdata
`ifdef GRAPH_LUT_READBACK_EN
  ,
  input  logic                   i_cfg_re,
  output logic [OUT_W-1:0]       o_cfg_rdata
`endif
);

  localparam int DEPTH = 1 << IDX_W;

  logic [OUT_W-1:0]       r_mem [DEPTH];
  logic [LANES*OUT_W-1:0] r_rdata;

  // Power-up contents only; reset never touches the table.
  initial begin
    for (int i = 0; i < DEPTH; i++) r_mem[i] = OUT_W'(sqrt_init(i, IDX_W, OUT_W));
  end

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      for (int l = 0; l < LANES; l++)
        r_rdata[l*OUT_W +: OUT_W] <= r_mem[i_raddr[l*IDX_W +: IDX_W]];
    end
  end

  assign o_rdata = r_rdata;

`ifdef GRAPH_LUT_READBACK_EN
  logic [OUT_W-1:0] r_cfg_rdata;

  // Non-blocking read of r_mem: a same-cycle write is not yet visible.
  always_ff @(posedge i_clk) begin
    if (i_rst)         r_cfg_rdata <= '0;
    else if (i_cfg_re) r_cfg_rdata <= r_mem[i_waddr];
  end

  assign o_cfg_rdata = r_cfg_rdata;
`endif

endmodule

// File: rtl/graph_lut_stream.sv
// graph_lut_stream: multi-lane streaming unary-op lookup engine.
// Optional macro: GRAPH_LUT_READBACK_EN adds i_cfg_re / o_cfg_rdata.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_start, i_len                job start (IDLE only) and beat count
//   o_busy, o_done                state != IDLE, one-cycle completion pulse
//   i_cfg_we/addr/wdata           table write (applied only when o_cfg_ready)
//   o_cfg_ready                   high in IDLE
//   i_in_valid/o_in_ready/i_in_data   input beats, lane i at [i*IDX_W +: IDX_W]
//   o_out_valid/i_out_ready/o_out_data output beats, lane i = table[in lane i]
//
// state    | meaning
// ST_IDLE  | waiting for start; table writable
// ST_RUN   | accepting beats until issued == len
// ST_DRAIN | waiting for the last beats to leave the output buffer
// ST_FIN   | done pulse, back to IDLE
module graph_lut_stream
  import graph_lut_pkg::*;
#(
  parameter int LANES = 4,
  parameter int IDX_W = 8,
  parameter int OUT_W = 8,
  parameter int LEN_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [LEN_W-1:0]       i_len,
  output logic                   o_busy,
  output logic                   o_done,
  input  logic                   i_cfg_we,
  input  logic [IDX_W-1:0]       i_cfg_addr,
  input  logic [OUT_W-1:0]       i_cfg_wdata,
  output logic                   o_cfg_ready,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [LANES*IDX_W-1:0] i_in_data,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [LANES*OUT_W-1:0] o_out_data
`ifdef GRAPH_LUT_READBACK_EN
  ,
  input  logic                   i_cfg_re,
  output logic [OUT_W-1:0]       o_cfg_rdata
`endif
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [LEN_W-1:0]       r_len;
  logic [LEN_W-1:0]       r_issued;
  logic [LEN_W-1:0]       r_retired;
  logic [LEN_W-1:0]       w_issued_nxt;
  logic [LEN_W-1:0]       w_retired_nxt;
  logic                   r_pipe_valid;
  logic [LANES*OUT_W-1:0] r_fifo [2];
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic [1:0]             r_count;
  logic [LANES*OUT_W-1:0] w_bank_data;
  logic                   w_in_fire;
  logic                   w_out_fire;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_start;

  assign w_start    = (r_state == ST_IDLE) && i_start;
  assign w_in_fire  = i_in_valid && o_in_ready;
  assign w_out_fire = o_out_valid && i_out_ready;

  // r_count + r_pipe_valid never exceeds 2, so the sum fits in two bits.
  assign o_in_ready = (r_state == ST_RUN) && (r_issued < r_len) &&
                      ((r_count + {1'b0, r_pipe_valid}) < 2'd2);

  assign w_issued_nxt  = r_issued  + {{(LEN_W-1){1'b0}}, w_in_fire};
  assign w_retired_nxt = r_retired + {{(LEN_W-1){1'b0}}, w_out_fire};

  // The bank's read register is the pipeline stage. When the buffer is empty
  // its data is presented directly (1-cycle latency); otherwise it is pushed
  // into the buffer behind the beats already waiting.
  assign w_push      = r_pipe_valid && !((r_count == 2'd0) && i_out_ready);
  assign w_pop       = (r_count != 2'd0) && i_out_ready;
  assign o_out_valid = (r_count != 2'd0) || r_pipe_valid;
  assign o_out_data  = (r_count != 2'd0) ? r_fifo[r_rd_ptr] : w_bank_data;

`ifdef GRAPH_LUT_READBACK_EN
  graph_lut_bank #(.LANES(LANES), .IDX_W(IDX_W), .OUT_W(OUT_W)) u_bank (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_we       (i_cfg_we && o_cfg_ready),
    .i_waddr    (i_cfg_addr),
    .i_wdata    (i_cfg_wdata),
    .i_re       (w_in_fire),
    .i_raddr    (i_in_data),
    .o_rdata    (w_bank_data),
    .i_cfg_re   (i_cfg_re && o_cfg_ready),
    .o_cfg_rdata(o_cfg_rdata)
  );
`else
  graph_lut_bank #(.LANES(LANES), .IDX_W(IDX_W), .OUT_W(OUT_W)) u_bank (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_we       (i_cfg_we && o_cfg_ready),
    .i_waddr    (i_cfg_addr),
    .i_wdata    (i_cfg_wdata),
    .i_re       (w_in_fire),
    .i_raddr    (i_in_data),
    .o_rdata    (w_bank_data)
  );
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Transitions look at the next counter values so DRAIN and FIN are entered
  // on the cycle after the last input and output handshakes respectively.
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    o_cfg_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_busy      = 1'b0;
        o_cfg_ready = 1'b1;
        if (i_start) w_state_nxt = (i_len == '0) ? ST_FIN : ST_RUN;
      end
      ST_RUN:   if (w_issued_nxt == r_len)  w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_retired_nxt == r_len) w_state_nxt = ST_FIN;
      ST_FIN: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len     <= '0;
      r_issued  <= '0;
      r_retired <= '0;
    end else if (w_start) begin
      r_len     <= i_len;
      r_issued  <= '0;
      r_retired <= '0;
    end else begin
      r_issued  <= w_issued_nxt;
      r_retired <= w_retired_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pipe_valid <= 1'b0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_count      <= 2'd0;
    end else begin
      r_pipe_valid <= w_in_fire;
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_bank_data;
  end

endmodule

// File: tb/tb_graph_lut_stream.sv
module tb_graph_lut_stream;
  localparam int LANES = 4;
  localparam int IDX_W = 8;
  localparam int OUT_W = 8;
  localparam int LEN_W = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [LEN_W-1:0]       len = '0;
  logic                   o_busy, o_done, o_cfg_ready, o_in_ready, o_out_valid;
  logic                   cfg_we = 1'b0;
  logic [IDX_W-1:0]       cfg_addr = '0;
  logic [OUT_W-1:0]       cfg_wdata = '0;
  logic                   in_valid = 1'b0;
  logic [LANES*IDX_W-1:0] in_data = '0;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] o_out_data;
`ifdef GRAPH_LUT_READBACK_EN
  logic                   cfg_re = 1'b0;
  logic [OUT_W-1:0]       o_cfg_rdata;
`endif

  graph_lut_stream #(.LANES(LANES), .IDX_W(IDX_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len),
    .o_busy(o_busy), .o_done(o_done),
    .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr), .i_cfg_wdata(cfg_wdata),
    .o_cfg_ready(o_cfg_ready),
    .i_in_valid(in_valid), .o_in_ready(o_in_ready), .i_in_data(in_data),
    .o_out_valid(o_out_valid), .i_out_ready(out_ready), .o_out_data(o_out_data)
`ifdef GRAPH_LUT_READBACK_EN
    , .i_cfg_re(cfg_re), .o_cfg_rdata(o_cfg_rdata)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference table: computed from the definition with real arithmetic.
  int tbl [256];
  function automatic int ref_entry(input int i);
    real s;
    int  v;
    s = (i < 128) ? real'(i) : real'(i - 256);
    if (s <= 0.0) return 0;
    v = $rtoi($floor($sqrt(s / 32.0) * 32.0 + 0.5));
    if (v > 127) v = 127;
    return v;
  endfunction

  function automatic logic [LANES*OUT_W-1:0] model_beat(input logic [LANES*IDX_W-1:0] d);
    logic [LANES*OUT_W-1:0] e;
    e = '0;
    for (int l = 0; l < LANES; l++) e[l*OUT_W +: OUT_W] = OUT_W'(tbl[int'(d[l*IDX_W +: IDX_W])]);
    return e;
  endfunction

  logic [LANES*OUT_W-1:0] sb [$];
  int cyc = 0;
  always @(posedge clk) cyc++;

  int job_len = 0;
  int n_out_job = 0;
  int last_hs_cyc = 0;
  int done_cnt = 0;
  bit hold_pend = 0;
  logic [LANES*OUT_W-1:0] hold_data;

  // Monitor: input handshakes push model results, output handshakes pop and compare.
  always @(negedge clk) begin
    logic [LANES*OUT_W-1:0] e;
    int size_before;
    if (rst) begin
      sb.delete();
      hold_pend = 0;
    end else begin
      size_before = sb.size();
      if (hold_pend) begin
        check("hold_valid", o_out_valid, 1);
        check("hold_data", o_out_data, hold_data);
      end
      hold_pend = o_out_valid && !out_ready;
      hold_data = o_out_data;
      if (size_before >= 2) check("in_ready_full", o_in_ready, 0);
      if (o_out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_out", 1, 0);
        else begin
          e = sb.pop_front();
          check("out_data", o_out_data, e);
        end
        n_out_job++;
        last_hs_cyc = cyc;
      end
      if (in_valid && o_in_ready) sb.push_back(model_beat(in_data));
      if (o_done) begin
        done_cnt++;
        check("done_beats", n_out_job, job_len);
        check("done_sb_empty", sb.size(), 0);
        if (job_len > 0) check("done_latency", cyc - last_hs_cyc, 1);
      end
    end
  end

  int or_mode = 0;
  int pat = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin out_ready = (pat == 0); pat = (pat + 1) % 3; end
        default: out_ready = 1'b0;
      endcase
    end
  end

  function automatic logic [LANES*IDX_W-1:0] gen_data(input bit use_fix, input logic [LANES*IDX_W-1:0] fix);
    logic [LANES*IDX_W-1:0] d;
    if (use_fix) return fix;
    for (int l = 0; l < LANES; l++) d[l*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, 255));
    return d;
  endfunction

  task automatic cfg_write(input int a, input int d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = IDX_W'(a); cfg_wdata = OUT_W'(d);
    tbl[a] = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // wr_mode: 0 none, 1 write in the start cycle (applied), 2 write during RUN (ignored)
  task automatic run_job(input int n, input bit use_fix, input logic [LANES*IDX_W-1:0] fix,
                         input bit stuck, input int wr_mode, input int wa, input int wd,
                         input bit chk_tp);
    int  t0;
    bit  ok;
    bit  got;
    @(posedge clk); #1;
    job_len = n; n_out_job = 0;
    start = 1'b1; len = LEN_W'(n);
    if (wr_mode == 1) begin
      cfg_we = 1'b1; cfg_addr = IDX_W'(wa); cfg_wdata = OUT_W'(wd); tbl[wa] = wd;
    end
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0; t0 = cyc;
    for (int b = 0; b < n; b++) begin
      if (!stuck && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = gen_data(use_fix, fix);
      if (wr_mode == 2 && b == 1) begin
        cfg_we = 1'b1; cfg_addr = IDX_W'(wa); cfg_wdata = OUT_W'(wd);
      end
      ok = 0;
      for (int w = 0; w < 100 && !ok; w++) begin
        @(negedge clk); ok = o_in_ready;
        @(posedge clk); #1; cfg_we = 1'b0;
      end
      if (!ok) begin check("accept_timeout", 0, 1); break; end
    end
    if (!stuck) in_valid = 1'b0;
    else in_data = gen_data(0, '0);
    got = 0;
    for (int w = 0; w < 300 && !got; w++) begin
      @(negedge clk); got = o_done;
    end
    if (!got) check("done_timeout", 0, 1);
    else if (chk_tp) check("throughput_cycles", cyc - t0, n + 1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", o_busy, 0);
  endtask

  initial begin
    int  acc;
    int  dc;
    bit  seen;
    for (int i = 0; i < 256; i++) tbl[i] = ref_entry(i);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_out_valid", o_out_valid, 0);
    check("rst_in_ready", o_in_ready, 0);
    check("rst_cfg_ready", o_cfg_ready, 1);
    check("rst_out_data", o_out_data, 0);
`ifdef GRAPH_LUT_READBACK_EN
    check("rst_cfg_rdata", o_cfg_rdata, 0);
`endif
    rst = 1'b0;

    // Default SQRT table, single beat, literal expectations
    seen = 0;
    fork
      run_job(1, 1, 32'h7F804020, 0, 0, 0, 0, 0);
      begin
        for (int w = 0; w < 20 && !seen; w++) begin
          @(negedge clk);
          if (o_out_valid) begin
            check("sqrt_literal", o_out_data, 32'h40002D20);
            seen = 1;
          end
        end
        if (!seen) check("sqrt_literal_timeout", 0, 1);
      end
    join

    // len == 0
    @(posedge clk); #1;
    job_len = 0; n_out_job = 0; start = 1'b1; len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("len0_busy", o_busy, 1);
    check("len0_done", o_done, 1);
    check("len0_out_valid", o_out_valid, 0);
    @(negedge clk);
    check("len0_busy_after", o_busy, 0);
    check("len0_done_after", o_done, 0);

    // Programmed entry; write during RUN must be ignored
    cfg_write(8'h05, 8'hAA);
    run_job(4, 1, 32'h05050505, 0, 2, 8'h05, 8'h11, 0);
    run_job(3, 1, 32'h05050505, 0, 0, 0, 0, 0);

    // Write and start in the same cycle
    run_job(2, 1, 32'h10101010, 0, 1, 8'h10, 8'h5A, 0);

    // Backpressure: in_valid stuck high, out_ready 1,0,0,...
    or_mode = 2; pat = 0;
    run_job(8, 0, '0, 1, 0, 0, 0, 0);

    // Full throughput
    or_mode = 0;
    run_job(16, 0, '0, 1, 0, 0, 0, 1);

    // Random jobs
    for (int j = 0; j < 6; j++) begin
      or_mode = 1;
      run_job($urandom_range(1, 20), 0, '0, j[0], 0, 0, 0, 0);
    end
    or_mode = 0;

    // Reset mid-job after 3 of 6 beats
    @(posedge clk); #1;
    job_len = 6; n_out_job = 0; start = 1'b1; len = 16'd6;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = gen_data(0, '0);
    acc = 0;
    for (int w = 0; w < 100 && acc < 3; w++) begin
      @(negedge clk);
      if (o_in_ready) acc++;
      @(posedge clk); #1;
      in_data = gen_data(0, '0);
    end
    check("abort_accepts", acc, 3);
    dc = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    check("abort_out_valid", o_out_valid, 0);
    check("abort_in_ready", o_in_ready, 0);
    check("abort_cfg_ready", o_cfg_ready, 1);
    check("abort_out_data", o_out_data, 0);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt, dc);
    run_job(2, 1, 32'h20407F05, 0, 0, 0, 0, 0);

`ifdef GRAPH_LUT_READBACK_EN
    cfg_write(8'h7F, 8'h33);
    @(posedge clk); #1;
    cfg_re = 1'b1; cfg_addr = 8'h7F;
    @(posedge clk); #1;
    cfg_re = 1'b0;
    check("rb_7f", o_cfg_rdata, OUT_W'(tbl[8'h7F]));
    @(posedge clk); #1;
    check("rb_hold", o_cfg_rdata, OUT_W'(tbl[8'h7F]));
    cfg_re = 1'b1; cfg_addr = 8'h40;
    @(posedge clk); #1;
    cfg_re = 1'b0;
    check("rb_40", o_cfg_rdata, OUT_W'(tbl[8'h40]));
    // Read and write together: old data returned, new data stored
    cfg_re = 1'b1; cfg_we = 1'b1; cfg_addr = 8'h41; cfg_wdata = 8'h77;
    @(posedge clk); #1;
    cfg_re = 1'b0; cfg_we = 1'b0;
    check("rb_rw_old", o_cfg_rdata, OUT_W'(tbl[8'h41]));
    tbl[8'h41] = 8'h77;
    cfg_re = 1'b1;
    @(posedge clk); #1;
    cfg_re = 1'b0;
    check("rb_rw_new", o_cfg_rdata, OUT_W'(tbl[8'h41]));
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
